// File: rtl/sound_arbiter.sv
// Shares one tone generator between four game-event sources by fixed priority (over > life > level > hit).
// Latency: tone_en rises the cycle after a request pulse; each tone lasts TONE_CYCLES, then a GAP_CYCLES silent gap.
// No backpressure: requests are one-cycle pulses latched into a pending set and merged if repeated.
// Optional: define SOUND_PREEMPT_EN to let a strictly higher-priority candidate abort the tone in progress.
module sound_arbiter #(
  parameter int unsigned TONE_CYCLES = 12500000,
  parameter int unsigned GAP_CYCLES  = 1250000,
  parameter int unsigned CNT_W       = 24,
  parameter logic [3:0]  TONE_HIT    = 4'd1,
  parameter logic [3:0]  TONE_LEVEL  = 4'd2,
  parameter logic [3:0]  TONE_LIFE   = 4'd3,
  parameter logic [3:0]  TONE_OVER   = 4'd4
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       mute,
  input  logic       req_hit,
  input  logic       req_level,
  input  logic       req_life,
  input  logic       req_over,
  output logic       tone_en,
  output logic [3:0] tone_code,
  output logic [3:0] grant,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  localparam logic [CNT_W-1:0] TONE_LAST = CNT_W'(TONE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       pending;
  logic             tone_on;

  logic [3:0] req_vec;
  logic [3:0] cand;
  logic [3:0] win;
  logic [3:0] win_code;
  logic       preempt;
  logic       take;
  logic [3:0] pending_nxt;

  // Candidate set and fixed-priority winner; bit order is {over, life, level, hit}.
  always_comb begin
    req_vec  = {req_over, req_life, req_level, req_hit};
    cand     = pending | req_vec;
    win      = 4'b0000;
    win_code = 4'd0;
    if (cand[3]) begin
      win      = 4'b1000;
      win_code = TONE_OVER;
    end else if (cand[2]) begin
      win      = 4'b0100;
      win_code = TONE_LIFE;
    end else if (cand[1]) begin
      win      = 4'b0010;
      win_code = TONE_LEVEL;
    end else if (cand[0]) begin
      win      = 4'b0001;
      win_code = TONE_HIT;
    end
  end

`ifdef SOUND_PREEMPT_EN
  // One-hot vectors compare numerically by priority, so a larger winner outranks the current grant.
  assign preempt = (state == PLAY) && (win > grant);
`else
  assign preempt = 1'b0;
`endif

  // Decide whether a new grant is issued this cycle, and update the pending set accordingly.
  always_comb begin
    take = 1'b0;
    case (state)
      IDLE:    take = |cand;
      PLAY:    take = preempt;
      GAP:     take = (cnt == GAP_LAST) && (|cand);
      default: take = 1'b0;
    endcase
    pending_nxt = cand & ~(take ? win : 4'b0000);
    // Game over supersedes queued hit and level-up sounds; life lost is kept.
    if (req_over) begin
      pending_nxt[1:0] = 2'b00;
    end
  end

  // Sequencer: owns state, duration counter, pending set and all registered outputs.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state     <= IDLE;
      cnt       <= '0;
      pending   <= 4'b0000;
      grant     <= 4'b0000;
      tone_code <= 4'd0;
      tone_on   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      pending <= pending_nxt;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (take) begin
            state     <= PLAY;
            grant     <= win;
            tone_code <= win_code;
            tone_on   <= 1'b1;
            busy      <= 1'b1;
          end
        end
        PLAY: begin
          if (preempt) begin
            grant     <= win;
            tone_code <= win_code;
            cnt       <= '0;
          end else if (cnt == TONE_LAST) begin
            state     <= GAP;
            cnt       <= '0;
            grant     <= 4'b0000;
            tone_code <= 4'd0;
            tone_on   <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt <= '0;
            if (take) begin
              state     <= PLAY;
              grant     <= win;
              tone_code <= win_code;
              tone_on   <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state     <= IDLE;
          cnt       <= '0;
          grant     <= 4'b0000;
          tone_code <= 4'd0;
          tone_on   <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  // Mute only silences the generator; sequencing is unaffected.
  assign tone_en = tone_on & ~mute;

endmodule

// File: tb/tb_sound_arbiter.sv
// Bench for sound_arbiter with TONE_CYCLES=4, GAP_CYCLES=2.
// Expected tones are queued by the stimulus; a negedge monitor pops one per new grant and checks code, enable, length and gap.
// Directed per-cycle checks cover reset, busy timing, mute and mid-tone reset.
module tb_sound_arbiter;

  localparam int TONE = 4;
  localparam int GAPC = 2;

  logic       clk = 1'b0;
  logic       resetN;
  logic       mute;
  logic       req_hit, req_level, req_life, req_over;
  logic       tone_en;
  logic [3:0] tone_code;
  logic [3:0] grant;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0] g;
    logic [3:0] code;
    logic       en;
    int         len;   // 0: not checked
    int         gap;   // -1: not checked
  } exp_t;

  exp_t exp_q[$];

  sound_arbiter #(
    .TONE_CYCLES(TONE),
    .GAP_CYCLES (GAPC),
    .CNT_W      (24)
  ) dut (
    .clk      (clk),
    .resetN   (resetN),
    .mute     (mute),
    .req_hit  (req_hit),
    .req_level(req_level),
    .req_life (req_life),
    .req_over (req_over),
    .tone_en  (tone_en),
    .tone_code(tone_code),
    .grant    (grant),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic exp_t mk(input logic [3:0] g, input logic [3:0] code, input logic en,
                              input int len, input int gap);
    exp_t e;
    e.g = g; e.code = code; e.en = en; e.len = len; e.gap = gap;
    return e;
  endfunction

  // Monitor: tracks tone boundaries at the negative edge and scores them against the queue.
  logic [3:0] prev_g = 4'b0;
  int         cur_len = 0;
  int         gap_cnt = 0;
  exp_t       cur;
  logic       cur_vld = 1'b0;

  always @(negedge clk) begin
    if (!resetN) begin
      prev_g  = 4'b0;
      cur_vld = 1'b0;
      cur_len = 0;
      gap_cnt = 0;
    end else begin
      if (prev_g != 4'b0 && grant != prev_g) begin
        if (cur_vld && cur.len != 0) chk("tone_len", cur_len, cur.len);
        cur_vld = 1'b0;
        gap_cnt = 0;
      end
      if (grant == 4'b0) begin
        gap_cnt++;
      end else if (grant != prev_g) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_grant", {28'b0, grant}, 32'h0);
        end else begin
          cur = exp_q.pop_front();
          cur_vld = 1'b1;
          chk("grant", {28'b0, grant}, {28'b0, cur.g});
          chk("tone_code", {28'b0, tone_code}, {28'b0, cur.code});
          chk("tone_en", {31'b0, tone_en}, {31'b0, cur.en});
          chk("busy_in_tone", {31'b0, busy}, 32'h1);
          if (cur.gap >= 0) chk("gap_len", gap_cnt, cur.gap);
        end
        cur_len = 1;
      end else begin
        cur_len++;
      end
      prev_g = grant;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Drives a one-cycle pulse on the selected sources; bit order {over, life, level, hit}.
  task automatic pulse(input logic [3:0] m);
    {req_over, req_life, req_level, req_hit} = m;
    cyc();
    {req_over, req_life, req_level, req_hit} = 4'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || grant != 4'b0) && n < 60) begin
      cyc();
      n++;
    end
    if (n >= 60) chk({name, "_timeout"}, 32'h1, 32'h0);
    cyc();
    chk({name, "_queue_drained"}, exp_q.size(), 0);
    chk({name, "_idle_code"}, {28'b0, tone_code}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    resetN = 1'b0;
    mute = 1'b0;
    {req_over, req_life, req_level, req_hit} = 4'b0;
    cyc(); cyc();
    chk("rst_tone_en", {31'b0, tone_en}, 32'h0);
    chk("rst_grant", {28'b0, grant}, 32'h0);
    chk("rst_code", {28'b0, tone_code}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    #3 resetN = 1'b1;
    cyc(); cyc();

    // 1: single hit; tone cycles 1-4, busy 1-6, idle at 7.
    exp_q.push_back(mk(4'b0001, 4'd1, 1'b1, 4, -1));
    pulse(4'b0001);
    for (int i = 1; i <= 7; i++) begin
      chk($sformatf("t1_busy_c%0d", i), {31'b0, busy}, {31'b0, (i <= 6)});
      chk($sformatf("t1_en_c%0d", i), {31'b0, tone_en}, {31'b0, (i <= 4)});
      if (i == 7) begin
        chk("t1_idle_grant", {28'b0, grant}, 32'h0);
        chk("t1_idle_code", {28'b0, tone_code}, 32'h0);
      end
      cyc();
    end
    wait_idle("t1");

    // 2: hit and life together; life first, 2-cycle gap, then hit.
    exp_q.push_back(mk(4'b0100, 4'd3, 1'b1, 4, -1));
    exp_q.push_back(mk(4'b0001, 4'd1, 1'b1, 4, 2));
    pulse(4'b0101);
    wait_idle("t2");

    // 3: level pulses twice during a hit tone.
`ifdef SOUND_PREEMPT_EN
    exp_q.push_back(mk(4'b0001, 4'd1, 1'b1, 2, -1));
    exp_q.push_back(mk(4'b0010, 4'd2, 1'b1, 4, 0));
    exp_q.push_back(mk(4'b0010, 4'd2, 1'b1, 4, 2));
`else
    exp_q.push_back(mk(4'b0001, 4'd1, 1'b1, 4, -1));
    exp_q.push_back(mk(4'b0010, 4'd2, 1'b1, 4, 2));
`endif
    pulse(4'b0001);
    cyc();
    pulse(4'b0010);
    pulse(4'b0010);
    wait_idle("t3");

    // 4: hit and level queue behind life; game over discards them.
`ifdef SOUND_PREEMPT_EN
    exp_q.push_back(mk(4'b0100, 4'd3, 1'b1, 3, -1));
    exp_q.push_back(mk(4'b1000, 4'd4, 1'b1, 4, 0));
`else
    exp_q.push_back(mk(4'b0100, 4'd3, 1'b1, 4, -1));
    exp_q.push_back(mk(4'b1000, 4'd4, 1'b1, 4, 2));
`endif
    pulse(4'b0100);
    pulse(4'b0001);
    pulse(4'b0010);
    pulse(4'b1000);
    wait_idle("t4");

    // 5: muted life tone keeps normal grant/busy timing with tone_en low.
    mute = 1'b1;
    exp_q.push_back(mk(4'b0100, 4'd3, 1'b0, 4, -1));
    pulse(4'b0100);
    for (int i = 1; i <= 7; i++) begin
      chk($sformatf("t5_en_c%0d", i), {31'b0, tone_en}, 32'h0);
      chk($sformatf("t5_grant_c%0d", i), {28'b0, grant}, (i <= 4) ? 32'h4 : 32'h0);
      chk($sformatf("t5_busy_c%0d", i), {31'b0, busy}, {31'b0, (i <= 6)});
      cyc();
    end
    mute = 1'b0;
    wait_idle("t5");

    // 6: reset in PLAY cycle 2 with hit pending; nothing plays afterwards.
    exp_q.push_back(mk(4'b0100, 4'd3, 1'b1, 0, -1));
    pulse(4'b0100);
    pulse(4'b0001);
    resetN = 1'b0;
    #1;
    chk("t6_rst_en", {31'b0, tone_en}, 32'h0);
    chk("t6_rst_grant", {28'b0, grant}, 32'h0);
    chk("t6_rst_code", {28'b0, tone_code}, 32'h0);
    chk("t6_rst_busy", {31'b0, busy}, 32'h0);
    cyc();
    #3 resetN = 1'b1;
    for (int i = 0; i < 15; i++) cyc();
    chk("t6_after_busy", {31'b0, busy}, 32'h0);
    chk("t6_after_grant", {28'b0, grant}, 32'h0);
    chk("t6_queue_drained", exp_q.size(), 0);

`ifdef SOUND_PREEMPT_EN
    // 7: over preempts hit in its second cycle; hit never resumes.
    exp_q.push_back(mk(4'b0001, 4'd1, 1'b1, 2, -1));
    exp_q.push_back(mk(4'b1000, 4'd4, 1'b1, 4, 0));
    pulse(4'b0001);
    pulse(4'b1000);
    wait_idle("t7");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sound_arbiter.md
Name: sound_arbiter

Overview:
- Shares the single board tone generator between the four game-event sound sources: obstacle hit, life lost, level up and game over.
- Latches one-cycle event pulses from the game controller and grants the generator to one source at a time, by fixed priority.
- Times each tone and the silent gap that follows it, then drives the tone code and enable into the tone generator.

Parameters:
- TONE_CYCLES, 12500000, clock cycles a granted tone stays enabled (must be >= 1).
- GAP_CYCLES, 1250000, silent cycles after every tone before the next grant (must be >= 1).
- CNT_W, 24, width of the shared duration counter (must hold max(TONE_CYCLES, GAP_CYCLES)).
- TONE_HIT / TONE_LEVEL / TONE_LIFE / TONE_OVER, 4'd1 / 4'd2 / 4'd3 / 4'd4, 4-bit tone code per source.

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- mute  in  1  forces tone_en low; sequencing and timing continue unchanged
- req_hit  in  1  one-cycle pulse, priority 0 (lowest)
- req_level  in  1  one-cycle pulse, priority 1
- req_life  in  1  one-cycle pulse, priority 2
- req_over  in  1  one-cycle pulse, priority 3 (highest)
- tone_en  out  1  tone generator enable
- tone_code  out  4  code of the granted source; 0 when no grant
- grant  out  4  one-hot granted source, bit order {over, life, level, hit}; 0 when idle
- busy  out  1  high in PLAY or GAP

Behaviour:
- Reset values: all outputs 0, pending[3:0] = 0, state IDLE, counter 0. An asserted reset in mid-tone stops the tone immediately and discards all pending requests.
- Pending register:
  - A pulse on req_x sets pending[x].
  - A second pulse while pending[x] is already set is merged; there is no count.
  - When a source is granted, its pending bit clears. A req_x arriving in the same cycle as its own grant is merged into that grant.
  - req_over clears pending[hit] and pending[level] in the same cycle, so game over supersedes them. pending[life] is kept.
- Arbitration: the candidate set is pending | req (this cycle). The highest set bit wins.
- States:
  - IDLE: if the candidate set is non-zero, go to PLAY with a registered grant. tone_en rises on the cycle after the request pulse, giving 1-cycle latency.
  - PLAY: tone_en = ~mute, and grant/tone_code are held. The counter runs for TONE_CYCLES cycles, then the block goes to GAP.
  - GAP: tone_en = 0, grant = 0, tone_code = 0. After GAP_CYCLES cycles:
    - if the candidate set is non-zero, go directly to PLAY (new grant);
    - otherwise go to IDLE.
- Timing rules:
  - Between back-to-back tones, tone_en is low for exactly GAP_CYCLES cycles.
  - Requests arriving in PLAY or GAP wait in pending. Without the optional feature they never shorten the current tone.
- Counter: it reloads on every state entry and never wraps. Its terminal value is TONE_CYCLES-1 or GAP_CYCLES-1.
- mute: only gates tone_en. grant, tone_code and busy behave identically whether mute is high or low.

Optional Feature:
- Macro: SOUND_PREEMPT_EN.
- Defined: in PLAY, a candidate of strictly higher priority than the current grant aborts the current tone.
  - The next cycle is PLAY with the new grant and the counter restarted. There is no gap.
  - The aborted source is dropped, not re-queued.
  - An equal- or lower-priority candidate does not preempt.
- Undefined: there is no preemption; behaviour is exactly as above.

Test Plan:
All scenarios use TONE_CYCLES=4 and GAP_CYCLES=2.
1. Single req_hit pulse at cycle 0 -> tone_en=1 and tone_code=1 for cycles 1-4, busy high cycles 1-6, idle at cycle 7 with all outputs 0.
2. req_hit and req_life pulsed in the same cycle -> life tone (code 3, grant=4'b0100) for 4 cycles, then 2 silent cycles, then hit tone (code 1) for 4 cycles.
3. req_level during a hit tone, then a second req_level pulse -> exactly one level tone follows the gap (merge); no preemption without the macro.
4. Pending hit and level, then req_over -> only the over tone plays (code 4); hit and level are never granted.
5. mute held high with req_life -> tone_en stays 0; grant=4'b0100 and busy follow the normal 4+2-cycle timing.
6. resetN low in PLAY cycle 2 with hit pending -> all outputs 0 immediately; after release, no tone plays. With SOUND_PREEMPT_EN, req_over in hit-tone cycle 2 -> over tone starts the next cycle and lasts 4 cycles, and hit is never resumed.
